// File: rtl/spi_cmd_pkg.sv
// Shared types and helpers for the SPI command bridge: FSM state encoding,
// command/status bit positions and status-word packing.
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        CMD,
        RD_REQ,
        RD_WAIT,
        DATA,
        WR_REQ
    } cmd_state_e;

    // Bit positions, counted down from the MSB of an SPI word
    localparam int unsigned W_OFS       = 0;
    localparam int unsigned LATE_OFS    = 0;
    localparam int unsigned OVERRUN_OFS = 1;
    localparam int unsigned TIMEOUT_OFS = 2;
    localparam int unsigned NFLAG       = 3;

    // Flag field that occupies the top NFLAG bits of the status word
    function automatic logic [NFLAG-1:0] pack_status(input logic late,
                                                     input logic overrun,
                                                     input logic timeout);
        logic [NFLAG-1:0] s;
        s = '0;
        s[NFLAG-1-LATE_OFS]    = late;
        s[NFLAG-1-OVERRUN_OFS] = overrun;
        s[NFLAG-1-TIMEOUT_OFS] = timeout;
        return s;
    endfunction

endpackage

// File: rtl/spi_cmd_if.sv
// Register-bus handshake between the SPI command bridge (master) and the
// register block (slave).
interface spi_cmd_if #(
    parameter int unsigned NBIT = 8
);
    logic            bus_req;
    logic            bus_we;
    logic [NBIT-2:0] bus_addr;
    logic [NBIT-1:0] bus_wdata;
    logic            bus_gnt;
    logic            bus_rvalid;
    logic [NBIT-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/spi_cmd_timer.sv
// Loadable saturating up-counter with a registered terminal-count flag.
module spi_cmd_timer #(
    parameter int unsigned MAX_CNT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);
    localparam int unsigned CW = $clog2(MAX_CNT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CW'(MAX_CNT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc    <= (cnt_d == CW'(MAX_CNT));
        end
    end
endmodule

// File: rtl/spi_cmd_bridge.sv
// Decodes two-frame SPI commands into register-bus reads/writes and returns
// read data or sticky status. Define SPI_CMD_TIMEOUT_EN to enable the data-frame timeout.
module spi_cmd_bridge
    import spi_cmd_pkg::*;
#(
    parameter int unsigned NBIT        = 8,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBIT-1:0] rx_data,
    input  logic            rx_strobe,
    input  logic            tx_strobe,
    output logic [NBIT-1:0] tx_data,
    spi_cmd_if.master       bus,
    output logic            err_irq
);
    localparam int unsigned AW = NBIT - 1;
    localparam int unsigned ZW = NBIT - NFLAG;

    cmd_state_e      state_q, state_d;
    logic [NBIT-1:0] txq_q, txq_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [NBIT-1:0] wdata_q, wdata_d;
    logic            late_q, late_d;
    logic            ovr_q, ovr_d;
    logic            to_q, to_d;
    logic            abandon_q, abandon_d;
    logic            tmr_tc;

`ifdef SPI_CMD_TIMEOUT_EN
    logic tmr_load;
    logic tmr_en;

    assign tmr_load = (state_d != state_q) && ((state_d == RD_REQ) || (state_d == DATA));
    assign tmr_en   = (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == DATA);

    spi_cmd_timer #(
        .MAX_CNT(TIMEOUT_CYC)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (tmr_load),
        .en   (tmr_en),
        .tc   (tmr_tc)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
    assign tmr_tc             = 1'b0;
`endif

    // Next-state and next-register logic
    always_comb begin
        state_d   = state_q;
        txq_d     = txq_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        late_d    = late_q;
        ovr_d     = ovr_q;
        to_d      = to_q;
        abandon_d = abandon_q;

        case (state_q)
            CMD: begin
                abandon_d = 1'b0;
                if (tx_strobe) begin
                    late_d = 1'b0;
                    ovr_d  = 1'b0;
                    to_d   = 1'b0;
                end
                if (rx_strobe) begin
                    we_d   = rx_data[NBIT-1-W_OFS];
                    addr_d = rx_data[AW-1:0];
                    if (rx_data[NBIT-1-W_OFS]) begin
                        state_d = DATA;
                    end else begin
                        req_d   = 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (tx_strobe) begin
                    late_d    = 1'b1;
                    abandon_d = 1'b1;
                end
                if (bus.bus_gnt) begin
                    req_d   = 1'b0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (tx_strobe) begin
                    late_d    = 1'b1;
                    abandon_d = 1'b1;
                end
                // A frame already started cannot carry this data; finish the read quietly
                if (bus.bus_rvalid) begin
                    if (abandon_q || tx_strobe) begin
                        state_d = CMD;
                    end else begin
                        txq_d   = bus.bus_rdata;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (tmr_tc) begin
                    to_d    = 1'b1;
                    state_d = CMD;
                end else if (rx_strobe) begin
                    if (we_q) begin
                        wdata_d = rx_data;
                        req_d   = 1'b1;
                        state_d = WR_REQ;
                    end else begin
                        state_d = CMD;
                    end
                end
            end
            WR_REQ: begin
                if (rx_strobe) begin
                    ovr_d = 1'b1;
                end
                if (bus.bus_gnt) begin
                    req_d   = 1'b0;
                    state_d = CMD;
                end
            end
            default: begin
                state_d = CMD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CMD;
            txq_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            late_q    <= 1'b0;
            ovr_q     <= 1'b0;
            to_q      <= 1'b0;
            abandon_q <= 1'b0;
            err_irq   <= 1'b0;
        end else begin
            state_q   <= state_d;
            txq_q     <= txq_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            late_q    <= late_d;
            ovr_q     <= ovr_d;
            to_q      <= to_d;
            abandon_q <= abandon_d;
            err_irq   <= late_d | ovr_d | to_d;
        end
    end

    // Idle shows live status; otherwise the last good read data
    assign tx_data = (state_q == CMD) ? {pack_status(late_q, ovr_q, to_q), {ZW{1'b0}}} : txq_q;

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Scoreboard bench for spi_cmd_bridge: SPI frame driver, register-bus responder,
// transfer monitor. Timeout scenario runs only when SPI_CMD_TIMEOUT_EN is defined.
module tb_spi_cmd_bridge;
    localparam int unsigned NBIT      = 8;
    localparam int unsigned TO_CYC    = 50;
    localparam int unsigned FRAME_CYC = 8;

    typedef struct packed {
        logic       we;
        logic [6:0] addr;
        logic [7:0] wdata;
    } xfer_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic       tx_strobe;
    logic [7:0] tx_data;
    logic       err_irq;

    spi_cmd_if #(.NBIT(NBIT)) bus_if ();

    spi_cmd_bridge #(
        .NBIT       (NBIT),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_strobe(rx_strobe),
        .tx_strobe(tx_strobe),
        .tx_data  (tx_data),
        .bus      (bus_if.master),
        .err_irq  (err_irq)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    xfer_t exp_bus[$];

    // Responder configuration
    int   gnt_dly   = 0;
    int   rv_lat    = 3;
    logic gnt_block = 1'b0;
    logic [7:0] rd_word = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_xfer(input logic we, input logic [6:0] addr, input logic [7:0] wdata);
        xfer_t x;
        x.we    = we;
        x.addr  = addr;
        x.wdata = wdata;
        exp_bus.push_back(x);
    endtask

    // One SPI frame: check the word the slave latches, then deliver the received word
    task automatic spi_frame(input logic [7:0] word, input logic [7:0] exp_tx, input string tag);
        @(negedge clk);
        check_eq({tag, "_tx"}, 32'(tx_data), 32'(exp_tx));
        @(posedge clk); #1 tx_strobe = 1'b1;
        @(posedge clk); #1 tx_strobe = 1'b0;
        repeat (FRAME_CYC - 2) @(posedge clk);
        #1;
        rx_data   = word;
        rx_strobe = 1'b1;
        @(posedge clk); #1 rx_strobe = 1'b0;
    endtask

    // Register-bus responder
    initial begin : responder
        int req_age;
        int rv_cnt;
        req_age = 0;
        rv_cnt  = -1;
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = 8'h00;
        forever begin
            @(posedge clk); #1;
            bus_if.bus_gnt    = 1'b0;
            bus_if.bus_rvalid = 1'b0;
            if (!rst_n) begin
                req_age = 0;
                rv_cnt  = -1;
                continue;
            end
            if (rv_cnt == 0) begin
                bus_if.bus_rvalid = 1'b1;
                bus_if.bus_rdata  = rd_word;
            end
            if (rv_cnt >= 0) rv_cnt--;
            if (bus_if.bus_req && !gnt_block) begin
                if (req_age >= gnt_dly) begin
                    bus_if.bus_gnt = 1'b1;
                    req_age = 0;
                    if (!bus_if.bus_we) rv_cnt = rv_lat - 1;
                end else begin
                    req_age++;
                end
            end else begin
                req_age = 0;
            end
        end
    end

    // Transfer monitor: scoreboard pop and request-hold rule
    initial begin : monitor
        xfer_t exp;
        logic        p_req;
        logic        p_gnt;
        logic [15:0] p_fields;
        p_req    = 1'b0;
        p_gnt    = 1'b0;
        p_fields = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_req = 1'b0;
                p_gnt = 1'b0;
                continue;
            end
            if (p_req && !p_gnt) begin
                check_eq("bus_hold",
                         32'({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata}),
                         32'({1'b1, p_fields}));
            end
            if (bus_if.bus_req && bus_if.bus_gnt) begin
                if (exp_bus.size() == 0) begin
                    check_eq("sb_underflow", 32'(exp_bus.size()), 32'd1);
                end else begin
                    exp = exp_bus.pop_front();
                    check_eq("xfer_we", 32'(bus_if.bus_we), 32'(exp.we));
                    check_eq("xfer_addr", 32'(bus_if.bus_addr), 32'(exp.addr));
                    if (exp.we) check_eq("xfer_wdata", 32'(bus_if.bus_wdata), 32'(exp.wdata));
                end
            end
            p_req    = bus_if.bus_req;
            p_gnt    = bus_if.bus_gnt;
            p_fields = {bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata};
        end
    end

    initial begin : watchdog
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] exp_status;
        int n;
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_strobe = 1'b0;
        tx_strobe = 1'b0;
        idle(3);
        @(negedge clk);
        check_eq("rst_tx", 32'(tx_data), 32'h00);
        check_eq("rst_req", 32'(bus_if.bus_req), 32'h0);
        check_eq("rst_we", 32'(bus_if.bus_we), 32'h0);
        check_eq("rst_addr", 32'(bus_if.bus_addr), 32'h0);
        check_eq("rst_wdata", 32'(bus_if.bus_wdata), 32'h0);
        check_eq("rst_irq", 32'(err_irq), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);

        // Write 0x85 / 0x3C, grant on the second request cycle
        gnt_dly = 1;
        expect_xfer(1'b1, 7'h05, 8'h3C);
        spi_frame(8'h85, 8'h00, "wr_cmd");
        spi_frame(8'h3C, 8'h00, "wr_dat");
        idle(6);
        check_eq("wr_status", 32'(tx_data), 32'h00);
        check_eq("wr_irq", 32'(err_irq), 32'h0);
        check_eq("wr_drain", 32'(exp_bus.size()), 32'd0);

        // Read 0x12, immediate grant, rvalid 3 cycles later with 0xA7
        gnt_dly = 0;
        rv_lat  = 3;
        rd_word = 8'hA7;
        expect_xfer(1'b0, 7'h12, 8'h00);
        spi_frame(8'h12, 8'h00, "rd_cmd");
        idle(6);
        spi_frame(8'hEE, 8'hA7, "rd_dat");
        idle(2);
        check_eq("rd_back_cmd", 32'(tx_data), 32'h00);
        check_eq("rd_drain", 32'(exp_bus.size()), 32'd0);

        // Late read: data frame starts long before rvalid
        rv_lat  = 20;
        rd_word = 8'h5A;
        expect_xfer(1'b0, 7'h12, 8'h00);
        spi_frame(8'h12, 8'h00, "late_cmd");
        spi_frame(8'h33, 8'hA7, "late_dat");
        idle(15);
        check_eq("late_irq", 32'(err_irq), 32'h1);
        check_eq("late_status", 32'(tx_data), 32'h80);

        // Overrun: write 0x81/0x55 stalled, extra frame arrives
        gnt_block = 1'b1;
        expect_xfer(1'b1, 7'h01, 8'h55);
        spi_frame(8'h81, 8'h80, "ovr_cmd");
        check_eq("late_irq_clr", 32'(err_irq), 32'h0);
        spi_frame(8'h55, 8'hA7, "ovr_dat");
        spi_frame(8'h99, 8'hA7, "ovr_extra");
        idle(2);
        check_eq("ovr_req_held", 32'(bus_if.bus_req), 32'h1);
        gnt_block = 1'b0;
        idle(6);
        check_eq("ovr_status", 32'(tx_data), 32'h40);
        check_eq("ovr_irq", 32'(err_irq), 32'h1);
        check_eq("ovr_drain", 32'(exp_bus.size()), 32'd0);

`ifdef SPI_CMD_TIMEOUT_EN
        // Write command with no data frame: timeout returns to idle
        spi_frame(8'h81, 8'h40, "to_cmd");
        n = 0;
        while ((tx_data !== 8'h20) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        check_eq("to_status", 32'(tx_data), 32'h20);
        check_eq("to_not_early", 32'(n >= int'(TO_CYC)), 32'h1);
        check_eq("to_not_late", 32'(n <= int'(TO_CYC) + 2), 32'h1);
        check_eq("to_irq", 32'(err_irq), 32'h1);
        check_eq("to_no_req", 32'(bus_if.bus_req), 32'h0);
        exp_status = 8'h20;
`else
        // Without the timeout the bridge waits for the data frame indefinitely
        spi_frame(8'h81, 8'h40, "nto_cmd");
        idle(120);
        n = 120;
        check_eq("nto_waiting", 32'(tx_data), 32'hA7);
        check_eq("nto_irq", 32'(err_irq), 32'h0);
        gnt_dly = 0;
        expect_xfer(1'b1, 7'h01, 8'h77);
        spi_frame(8'h77, 8'hA7, "nto_dat");
        idle(4);
        check_eq("nto_status", 32'(tx_data), 32'h00);
        check_eq("nto_drain", 32'(exp_bus.size()), 32'd0);
        exp_status = 8'h00;
`endif

        // Reset while a read request is outstanding
        gnt_block = 1'b1;
        spi_frame(8'h12, exp_status, "rst_cmd");
        idle(3);
        check_eq("rstop_req_pre", 32'(bus_if.bus_req), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("rstop_req", 32'(bus_if.bus_req), 32'h0);
        check_eq("rstop_tx", 32'(tx_data), 32'h00);
        check_eq("rstop_addr", 32'(bus_if.bus_addr), 32'h00);
        check_eq("rstop_irq", 32'(err_irq), 32'h0);
        idle(2);
        rst_n     = 1'b1;
        gnt_block = 1'b0;
        idle(2);

        // Clean write afterwards, boundary address and data
        gnt_dly = 1;
        expect_xfer(1'b1, 7'h7F, 8'hFF);
        spi_frame(8'hFF, 8'h00, "post_cmd");
        spi_frame(8'hFF, 8'h00, "post_dat");
        idle(6);
        check_eq("post_status", 32'(tx_data), 32'h00);
        check_eq("post_irq", 32'(err_irq), 32'h0);
        check_eq("post_drain", 32'(exp_bus.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_cmd_bridge.md
Name: spi_cmd_bridge

Overview:
- Sits directly downstream of the SPI slave interface in the system clk domain.
- Consumes its received words (rx_data/rx_strobe) and feeds it the next word to shift out (tx_data, sampled while ss_n is high).
- Decodes a two-frame command protocol (command word, then data word) into single read/write transactions on a req/gnt register bus.
- Returns read data, or a status word, to the SPI master.

Parameters:
- NBIT, 8: SPI word width; must match the SPI slave. Address width = NBIT-1.
- TIMEOUT_CYC, 1_000_000: clk cycles allowed between the command frame's rx_strobe and the data frame's rx_strobe.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- rx_data  in  NBIT  word received by the SPI slave; valid when rx_strobe is high
- rx_strobe  in  1  one-cycle pulse: a frame has ended
- tx_strobe  in  1  one-cycle pulse: a frame has started; the slave latched tx_data from the previous cycle
- tx_data  out  NBIT  word to shift out in the next frame
- bus_req  out  1  transaction request
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  NBIT-1  register address
- bus_wdata  out  NBIT  write data
- bus_gnt  in  1  request accepted; transfer occurs on bus_req & bus_gnt
- bus_rvalid  in  1  read data valid, one-cycle pulse
- bus_rdata  in  NBIT  read data
- err_irq  out  1  high while any sticky error flag is set

Behaviour:
- Interface decision: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: FSM = CMD; tx_data = 0; bus_req = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0; all flags = 0; err_irq = 0.
- Command word: bit NBIT-1 = W (1 write, 0 read); bits NBIT-2:0 = address.
- Status word: {late, overrun, timeout, zeros}. The three flags are sticky.
- States and transitions:
  - CMD: tx_data = status word. On rx_strobe, latch the address and W into bus_addr/bus_we.
    - W = 0 -> RD_REQ.
    - W = 1 -> DATA.
  - RD_REQ: bus_req = 1, fields held stable. On bus_gnt -> RD_WAIT, bus_req drops the next cycle.
  - RD_WAIT: on bus_rvalid, register bus_rdata into tx_data -> DATA.
    - Latency from bus_rvalid to tx_data update: 1 cycle.
  - DATA: waiting for the data frame.
    - Read: on rx_strobe, discard rx_data -> CMD.
    - Write: on rx_strobe, bus_wdata <= rx_data -> WR_REQ.
  - WR_REQ: bus_req = 1, bus_we = 1. On bus_gnt -> CMD.
- Status handling:
  - In CMD, tx_strobe clears all flags.
  - Flags set in that same cycle take priority over the clear.
  - While in CMD, tx_data tracks the status word combinationally from registered flags.
- Data frame starts before read data is ready (tx_strobe in RD_REQ or RD_WAIT):
  - Set late.
  - Finish the bus read, but do not load tx_data.
  - A subsequent rx_strobe in those states is ignored.
  - On bus_rvalid -> CMD instead of DATA.
- rx_strobe in WR_REQ (new frame while a write is pending): set overrun, drop the word; the write still completes.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYC+1).
  - Cleared on entering RD_REQ or DATA; counts in RD_REQ, RD_WAIT and DATA.
  - At TIMEOUT_CYC in DATA: set timeout -> CMD.
  - In RD states the counter saturates and is never acted on, because the bus transaction cannot be abandoned.
- Bus rule: once bus_req is high it stays high, with stable bus_we, bus_addr and bus_wdata, until bus_gnt is sampled high.
- err_irq = late | overrun | timeout, registered.
- Asynchronous reset mid-operation returns everything to reset values, including a bus_req in flight. The bus side must tolerate an abandoned request.

Optional Feature:
- Macro: SPI_CMD_TIMEOUT_EN.
- Defined: timeout counter and timeout flag behave as described.
- Undefined: no counter; DATA waits indefinitely; the timeout status bit is tied to 0; TIMEOUT_CYC is unused.

Decomposition:
- Shared package spi_cmd_pkg holds:
  - state enum cmd_state_e: CMD, RD_REQ, RD_WAIT, DATA, WR_REQ;
  - localparam bit positions for W, LATE, OVERRUN and TIMEOUT;
  - function pack_status().
- Natural sub-module: spi_cmd_timer, a loadable saturating counter with a terminal-count flag, instantiated only under SPI_CMD_TIMEOUT_EN.

Test Plan:
- Write: frame 0x85, then frame 0x3C, bus_gnt on the 2nd req cycle -> one transfer with bus_we = 1, bus_addr = 0x05, bus_wdata = 0x3C; FSM back to CMD; err_irq = 0.
- Read: frame 0x12, bus_gnt immediately, bus_rvalid 3 cycles later with 0xA7, data frame after that -> tx_data = 0xA7 at tx_strobe; back to CMD after rx_strobe.
- Late read: frame 0x12, data frame tx_strobe before bus_rvalid -> late set, tx_data stays 0xA7 from the prior read; next command frame shifts out status 0x80, flags clear, err_irq falls.
- Overrun: write 0x81/0x55 with bus_gnt held low, then another frame -> overrun set; exactly one transfer (addr 0x01, data 0x55) on grant; status 0x40.
- Timeout (with macro, TIMEOUT_CYC = 50): frame 0x81 and no further frame -> back to CMD at cycle 50; status 0x20; no bus_req.
- Reset mid-RD_REQ: rst_n low -> bus_req = 0 and tx_data = 0 immediately; after release a clean write completes normally.
